// File: rtl/fb_rect_writer.sv
// Write side of the 160x120 4-bit frame buffer: fills clipped rectangles or the
// whole screen, one pixel write per clock in raster order (ADDR = y*H_RES + x).
`timescale 1ns/1ps
module fb_rect_writer #(
    parameter int H_RES  = 160,
    parameter int V_RES  = 120,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 4
) (
    input  logic              FB_CLK,
    input  logic              FB_RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_CLEAR,
    input  logic [7:0]        CMD_X,
    input  logic [6:0]        CMD_Y,
    input  logic [7:0]        CMD_W,
    input  logic [6:0]        CMD_H,
    input  logic [DATA_W-1:0] CMD_COLOUR,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FIN} state_t;

    state_t              state_q, state_d;
    logic [7:0]          x_q, x_d, x_start_q, x_start_d, x_last_q, x_last_d;
    logic [6:0]          y_q, y_d, y_last_q, y_last_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d, addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wr_en_q, wr_en_d, ready_q, ready_d;
    logic                busy_q, busy_d, done_q, done_d;

    // Clip the incoming command; 9-bit sums so X+W and Y+H never wrap.
    logic [8:0]          x_sum, y_sum, x_end, y_end;
    logic [7:0]          cmd_x0;
    logic [6:0]          cmd_y0;
    logic                cmd_empty;
    logic [ADDR_W-1:0]   cmd_row0;

    always_comb begin
        x_sum     = {1'b0, CMD_X} + {1'b0, CMD_W};
        y_sum     = {2'b00, CMD_Y} + {2'b00, CMD_H};
        x_end     = (x_sum > 9'(H_RES)) ? 9'(H_RES) : x_sum;
        y_end     = (y_sum > 9'(V_RES)) ? 9'(V_RES) : y_sum;
        cmd_x0    = CMD_X;
        cmd_y0    = CMD_Y;
        cmd_empty = (CMD_W == 8'd0) || (CMD_H == 7'd0) ||
                    ({1'b0, CMD_X} >= 9'(H_RES)) || ({2'b00, CMD_Y} >= 9'(V_RES));
        if (CMD_CLEAR) begin
            cmd_x0    = 8'd0;
            cmd_y0    = 7'd0;
            x_end     = 9'(H_RES);
            y_end     = 9'(V_RES);
            cmd_empty = 1'b0;
        end
        // Constant-coefficient product: only the starting row, reduces to shift-add.
        cmd_row0 = ADDR_W'(cmd_y0) * ADDR_W'(H_RES);
    end

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d    = state_q;
        x_d        = x_q;
        x_start_d  = x_start_q;
        x_last_d   = x_last_q;
        y_d        = y_q;
        y_last_d   = y_last_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_en_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID && ready_q) begin
                    if (cmd_empty) begin
                        state_d = S_FIN;
                    end else begin
                        state_d    = S_FILL;
                        wr_en_d    = 1'b1;
                        x_d        = cmd_x0;
                        x_start_d  = cmd_x0;
                        x_last_d   = 8'(x_end - 9'd1);
                        y_d        = cmd_y0;
                        y_last_d   = 7'(y_end - 9'd1);
                        row_base_d = cmd_row0;
                        addr_d     = cmd_row0 + ADDR_W'(cmd_x0);
                        data_d     = CMD_COLOUR;
                    end
                end
            end
            S_FILL: begin
                wr_en_d = 1'b1;
                if (x_q == x_last_q) begin
                    if (y_q == y_last_q) begin
                        state_d = S_FIN;
                        wr_en_d = 1'b0;
                    end else begin
                        x_d        = x_start_q;
                        y_d        = y_q + 7'd1;
                        row_base_d = row_base_q + ADDR_W'(H_RES);
                        addr_d     = row_base_q + ADDR_W'(H_RES) + ADDR_W'(x_start_q);
                    end
                end else begin
                    x_d    = x_q + 8'd1;
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_FILL);
        done_d  = (state_d == S_FIN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge FB_CLK or posedge FB_RST) begin
        if (FB_RST) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            x_start_q  <= '0;
            x_last_q   <= '0;
            y_q        <= '0;
            y_last_q   <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            x_start_q  <= x_start_d;
            x_last_q   <= x_last_d;
            y_q        <= y_d;
            y_last_q   <= y_last_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign CMD_READY = ready_q;
    assign WR_EN     = wr_en_q;
    assign WR_ADDR   = addr_q;
    assign WR_DATA   = data_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule
